// File: rtl/serial_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// Sticky frame-error and overrun flags; synchronous active-low reset.
module serial_rx_fifo #(
  parameter int unsigned DEPTH   = 5,
  parameter int unsigned CLK_DIV = 27
) (
  input  logic             CLK_WR,
  input  logic             RST,
  input  logic             RX,
  input  logic             RD_EN,
  input  logic             CLR_ERR,
  output logic [7:0]       DATA,
  output logic             EMPTY,
  output logic             FULL,
  output logic [DEPTH:0]   COUNT,
  output logic             FERR,
  output logic             OVERRUN
);

  localparam int unsigned N    = 2 ** DEPTH;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]  DivMax    = DivW'(CLK_DIV - 1);
  localparam logic [DEPTH:0]   CountFull = (DEPTH + 1)'(N);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [3:0]        os_q, os_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_meta_q, rxs_q, rx_last_q;
  logic [DivW-1:0]   div_q;
  logic              tick;
  logic              push, frame_err;

  logic [7:0]        mem [N];
  logic [DEPTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH:0]    count_q, count_d;
  logic              ferr_q, overrun_q;
  logic              pop, push_ok, overrun_set;

  assign tick = (div_q == DivMax);

  // Synchronizer, divider and previous-tick line sample
  always_ff @(posedge CLK_WR) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rx_last_q <= 1'b1;
      div_q     <= '0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      div_q     <= tick ? '0 : div_q + 1'b1;
      if (tick) rx_last_q <= rxs_q;
    end
  end

  // FSM state register
  always_ff @(posedge CLK_WR) begin
    if (!RST) begin
      state_q <= StIdle;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          // Falling edge only: a held-low line never retriggers
          if (!rxs_q && rx_last_q) begin
            state_d = StStart;
            os_d    = '0;
          end
        end
        StStart: begin
          if (os_q == 4'd7) begin
            os_d    = '0;
            bit_d   = '0;
            state_d = rxs_q ? StIdle : StData;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
        StData: begin
          if (os_q == 4'd15) begin
            shift_d = {rxs_q, shift_q[7:1]};
            os_d    = '0;
            if (bit_q == 3'd7) state_d = StStop;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
        StStop: begin
          if (os_q == 4'd15) begin
            os_d    = '0;
            state_d = StIdle;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
    if (tick && (state_q == StStop) && (os_q == 4'd15)) begin
      push      = rxs_q;
      frame_err = ~rxs_q;
    end
  end

  assign pop         = RD_EN && (count_q != '0);
  assign push_ok     = push && ((count_q != CountFull) || pop);
  assign overrun_set = push && !push_ok;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK_WR) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Set has priority over clear
      if (frame_err)    ferr_q <= 1'b1;
      else if (CLR_ERR) ferr_q <= 1'b0;
      if (overrun_set)  overrun_q <= 1'b1;
      else if (CLR_ERR) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK_WR) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  assign DATA    = mem[rd_ptr_q];
  assign EMPTY   = (count_q == '0);
  assign FULL    = (count_q == CountFull);
  assign COUNT   = count_q;
  assign FERR    = ferr_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo: serial frames in, scoreboard of expected FIFO bytes out.
module tb_serial_rx_fifo;

  localparam int unsigned DEPTH   = 5;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BIT_CYC = 16 * CLK_DIV;
  localparam int unsigned NBYTES  = 2 ** DEPTH;

  logic             clk;
  logic             rst;
  logic             rx;
  logic             rd_en;
  logic             clr_err;
  logic [7:0]       data;
  logic             empty;
  logic             full;
  logic [DEPTH:0]   count;
  logic             ferr;
  logic             overrun;

  logic [7:0] sb [$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         seen;
  logic [7:0] exp_b;

  serial_rx_fifo #(
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .CLK_WR  (clk),
    .RST     (rst),
    .RX      (rx),
    .RD_EN   (rd_en),
    .CLR_ERR (clr_err),
    .DATA    (data),
    .EMPTY   (empty),
    .FULL    (full),
    .COUNT   (count),
    .FERR    (ferr),
    .OVERRUN (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, stop; leaves the line at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(BIT_CYC);
    end
    rx = stop;
    cycles(BIT_CYC);
    if (stop) cycles(16);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
  endtask

  task automatic wait_push();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (dut.push) seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(2);

    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ferr", ferr, 0);
    check("rst_overrun", overrun, 0);

    // Single byte, with first-word fall-through timing
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_push();
        check("a5_push_seen", seen, 1);
        check("a5_empty_on_push_cycle", empty, 1);
        cycles(1);
        check("a5_empty_next_cycle", empty, 0);
        check("a5_head_next_cycle", data, sb[0]);
      end
    join
    check("a5_count", count, 1);
    check("a5_ferr", ferr, 0);
    exp_b = sb.pop_front();
    check("a5_data", data, exp_b);
    pulse_rd();
    check("a5_pop_empty", empty, 1);
    check("a5_pop_count", count, 0);

    // Short low glitch rejected
    rx = 1'b0;
    cycles(16);
    rx = 1'b1;
    cycles(200);
    check("glitch_count", count, 0);
    check("glitch_ferr", ferr, 0);

    // Framing error, then a long break
    send_frame(8'h3C, 1'b0);
    check("ferr_set", ferr, 1);
    check("ferr_count", count, 0);
    cycles(20 * BIT_CYC);
    check("break_count", count, 0);
    check("break_empty", empty, 1);
    rx = 1'b1;
    cycles(BIT_CYC);
    check("ferr_sticky", ferr, 1);
    pulse_clr();
    check("ferr_cleared", ferr, 0);

    // Fill past capacity
    for (int i = 0; i <= 32; i++) begin
      if (sb.size() < NBYTES) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 32);
    check("fill_overrun", overrun, 1);
    check("fill_empty", empty, 0);
    pulse_clr();
    check("overrun_cleared", overrun, 0);

    // Push while full with a pop in the same cycle
    fork
      send_frame(8'h21, 1'b1);
      begin
        wait_push();
        check("full_push_seen", seen, 1);
        if (seen) begin
          exp_b = sb.pop_front();
          check("full_pop_head", data, exp_b);
          sb.push_back(8'h21);
          pulse_rd();
        end
      end
    join
    check("full_push_count", count, 32);
    check("full_push_overrun", overrun, 0);
    check("full_push_full", full, 1);

    // Drain across the pointer wrap
    for (int i = 0; i < NBYTES; i++) begin
      check("drain_not_empty", empty, 0);
      exp_b = sb.pop_front();
      check("drain_data", data, exp_b);
      pulse_rd();
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    pulse_rd();
    check("pop_on_empty_count", count, 0);
    check("pop_on_empty_empty", empty, 1);

    // Reset in the middle of a frame
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    check("pre_rst_count", count, 1);
    exp_b = 8'h77;
    rx = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = exp_b[i];
      cycles(BIT_CYC);
    end
    rx = exp_b[4];
    cycles(BIT_CYC / 2);
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    sb.delete();
    cycles(1);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_ferr", ferr, 0);
    rx = 1'b1;
    cycles(200);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("post_rst_count", count, 1);
    check("post_rst_ferr", ferr, 0);
    exp_b = sb.pop_front();
    check("post_rst_data", data, exp_b);
    pulse_rd();
    check("post_rst_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 5, FIFO holds N=2**DEPTH bytes.
REQ-002 Parameter CLK_DIV, default 27, CLK_WR cycles per oversample tick; 16 ticks per bit.
REQ-003 CLK_WR  in  1  system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-low.
REQ-005 RX  in  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 RD_EN  in  1  pop request; ignored while EMPTY=1.
REQ-007 CLR_ERR  in  1  clears sticky FERR and OVERRUN.
REQ-008 DATA  out  8  FIFO head byte, combinational from memory (first-word fall-through).
REQ-009 EMPTY  out  1  FIFO holds zero bytes.
REQ-010 FULL  out  1  FIFO holds N bytes.
REQ-011 COUNT  out  DEPTH+1  number of stored bytes, 0..N.
REQ-012 FERR  out  1  sticky: a frame had stop bit 0.
REQ-013 OVERRUN  out  1  sticky: a received byte was dropped because the FIFO was full.

Function
REQ-014 RX shall pass through a 2-flop synchronizer; rxs denotes the second flop.
REQ-015 A divider shall count 0..CLK_DIV-1 and free-run; tick shall be high for one cycle when it reaches CLK_DIV-1.
REQ-016 The FSM shall have states IDLE, START, DATA and STOP, shall act only on tick cycles, and shall keep os_cnt (4 bits) and bit_cnt (3 bits).
REQ-017 IDLE: on a tick with rxs=0 and previous-tick sample rx_last=1, go to START with os_cnt=0; a line held low (break) shall not retrigger.
REQ-018 START: os_cnt increments per tick; at os_cnt=7, rxs=0 goes to DATA with os_cnt=0 and bit_cnt=0; rxs=1 returns to IDLE (glitch rejected, no flags).
REQ-019 DATA: at os_cnt=15, shift rxs into shift register bit 7 (right shift, LSB first), then set os_cnt=0; after the sample with bit_cnt=7 go to STOP, else increment bit_cnt.
REQ-020 STOP: at os_cnt=15, rxs=1 issues a one-cycle push of the shift register; rxs=0 sets FERR with no push; both outcomes go to IDLE.
REQ-021 Pushed byte shall appear on DATA with EMPTY=0 one CLK_WR cycle after the stop-sample tick, if the FIFO was previously empty.
REQ-022 Push shall be accepted when COUNT<N, or when COUNT=N and a valid RD_EN occurs in the same cycle; otherwise the byte is dropped and OVERRUN is set.
REQ-023 Valid pop (RD_EN=1, EMPTY=0) shall advance rd_ptr by 1; DATA shows the next byte the following cycle.
REQ-024 Simultaneous push and pop shall leave COUNT unchanged; pointers shall be DEPTH bits and wrap modulo N.
REQ-025 Pop on empty and push on full without a pop shall leave pointers and COUNT unchanged.
REQ-026 CLR_ERR=1 shall clear FERR and OVERRUN next cycle; if a set event occurs in the same cycle, set wins.

Reset
REQ-027 RST=0 at a clock edge shall force IDLE, os_cnt=0, bit_cnt=0, divider=0, pointers=0, COUNT=0, EMPTY=1, FULL=0, FERR=0, OVERRUN=0, synchronizer and rx_last=1.
REQ-028 FIFO memory shall not be reset; DATA is undefined while EMPTY=1.
REQ-029 Reset mid-frame shall discard the partial byte; the FSM re-arms only after rxs is seen high (REQ-017).

Verification
REQ-030 Use CLK_DIV=4 and DEPTH=5; send 0xA5 as an 8N1 frame with 64 cycles per bit -> COUNT=1, DATA=0xA5, EMPTY=0, FERR=0; pulse RD_EN -> EMPTY=1, COUNT=0.
REQ-031 Pull RX low for 16 cycles, then high -> no push, COUNT=0, FERR=0, FSM back in IDLE.
REQ-032 Send 0x3C with stop bit 0 -> FERR=1, COUNT=0; hold RX low for 20 bit-times -> no further frames; pulse CLR_ERR -> FERR=0.
REQ-033 Send 33 bytes 0x00..0x20 with no reads -> FULL=1, COUNT=32, OVERRUN=1; drain -> bytes read are 0x00..0x1F in order, with correct pointer wrap.
REQ-034 With FIFO full, assert RD_EN on the push cycle of a new byte -> byte accepted, COUNT=32, OVERRUN unchanged.
REQ-035 Assert RST=0 during bit 4 of a frame, then release and send 0x5A -> only 0x5A is stored, COUNT=1.
